// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, 1 stop bit, LSB first, fed from a byte FIFO.
// Defining UART_TX_PARITY_EN adds an even-parity bit between DATA and STOP.
module uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_pin,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int            PW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [15:0]   DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pin_q, pin_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          push_s, pop_s, bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign tx_ready   = (count_q != DEPTH_C);
  assign tx_busy    = (state_q != S_IDLE) || (count_q != ZERO_C);
  assign tx_pin     = pin_q;
  assign fifo_count = count_q;
  assign push_s     = tx_valid && tx_ready && !rst;
  assign bit_end_s  = (cnt_q == DIV_LAST);

  // Next-state, bit timing, line level and FIFO pointer/occupancy update.
  always_comb begin
    state_d = state_q;
    cnt_d   = 16'd0;
    bit_d   = bit_q;
    shift_d = shift_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    pin_d   = 1'b1;
    pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q == S_IDLE || bit_end_s) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    // pin_d reflects the current state, so the line trails the FSM by one cycle.
    case (state_q)
      S_IDLE: begin
        pin_d = 1'b1;
        if (count_q != ZERO_C) begin
          state_d = S_START;
          pop_s   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        pin_d = 1'b0;
        if (bit_end_s) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        pin_d = shift_q[0];
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        pin_d = par_q;
        if (bit_end_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        pin_d = 1'b1;
        if (bit_end_s) begin
          if (count_q != ZERO_C) begin
            state_d = S_START;
            pop_s   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        pin_d   = 1'b1;
      end
    endcase
    if (pop_s) begin
      shift_d = mem_q[rd_q];
      rd_d    = rd_q + PW'(1'b1);
`ifdef UART_TX_PARITY_EN
      par_d   = even_parity(mem_q[rd_q]);
`endif
    end else begin
      rd_d = rd_q;
    end
    if (push_s) begin
      wr_d = wr_q + PW'(1'b1);
    end else begin
      wr_d = wr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      rd_q    <= {PW{1'b0}};
      wr_q    <= {PW{1'b0}};
      count_q <= ZERO_C;
      pin_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      pin_q   <= pin_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard plus line-level receiver model on a
// CLK_DIV=4 instance, and a directed waveform check on a CLK_DIV=2 instance.
module tb_uart_tx;
  localparam int DIV  = 4;
  localparam int DIV2 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_pin, tx_busy;
  logic       tx_ready2, tx_pin2, tx_busy2;
  logic [2:0] fifo_count, fifo_count2;

  int ncmp = 0;
  int nfail = 0;
  logic [7:0] sbq[$];

  always #5 clk = ~clk;

  uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_pin(tx_pin), .tx_busy(tx_busy), .fifo_count(fifo_count));

  uart_tx #(.CLK_DIV(DIV2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .tx_pin(tx_pin2), .tx_busy(tx_busy2), .fifo_count(fifo_count2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f      = 11'h7FF;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  // Receiver model: detects a start bit, demands every bit be constant for DIV samples.
  int         cyc = 0;
  int         end_cyc = -100;
  int         mc = 0;
  bit         mon_in = 1'b0;
  bit         glitch = 1'b0;
  bit         expect_b2b = 1'b0;
  logic [10:0] fb;
  always @(negedge clk) begin
    int k, b;
    logic [7:0] exp_b;
    cyc++;
    if (rst) begin
      mon_in = 1'b0;
    end else if (!mon_in) begin
      if (tx_pin === 1'b0) begin
        chk("frame_expected", 32'(sbq.size() != 0), 32'd1);
        if (expect_b2b) chk("b2b_gap", 32'(cyc - end_cyc - 1), 32'd0);
        expect_b2b = 1'b0;
        mon_in = 1'b1;
        mc = 1;
        fb = 11'h000;
        glitch = 1'b0;
      end
    end else begin
      k = mc % DIV;
      b = mc / DIV;
      if (k == 0) fb[b] = tx_pin;
      else if (tx_pin !== fb[b]) glitch = 1'b1;
      mc++;
      if (mc == NB * DIV) begin
        mon_in = 1'b0;
        chk("rx_have_exp", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          exp_b = sbq.pop_front();
          chk("rx_data", 32'(fb[8:1]), 32'(exp_b));
`ifdef UART_TX_PARITY_EN
          chk("rx_parity", 32'(fb[9]), 32'(^exp_b));
`endif
          chk("rx_stop", 32'(fb[NB-1]), 32'd1);
          chk("rx_bit_width", 32'(glitch), 32'd0);
        end
        end_cyc = cyc;
        expect_b2b = (sbq.size() != 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte until the handshake completes; tx_valid is left asserted.
  task automatic push(input logic [7:0] d, input int maxw);
    bit   ok = 1'b0;
    logic r;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < maxw && !ok; i++) begin
      @(negedge clk);
      r = tx_ready;
      @(posedge clk);
      #1;
      if (r === 1'b1) ok = 1'b1;
    end
    if (ok) sbq.push_back(d);
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int maxc);
    bit done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !mon_in && tx_busy === 1'b0) done = 1'b1;
    end
    chk("drain", 32'(done), 32'd1);
    step();
  endtask

  initial begin
    logic [10:0] f, fa, fz;
    int j;
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hEE; tx_valid2 = 1'b0; tx_data2 = 8'h00;
    repeat (3) step();
    chk("rst_pin", 32'(tx_pin), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_pin2", 32'(tx_pin2), 32'd1);
    chk("rst_count2", 32'(fifo_count2), 32'd0);
    tx_valid = 1'b0; rst = 1'b0;
    step();
    chk("post_rst_count", 32'(fifo_count), 32'd0);
    chk("post_rst_busy", 32'(tx_busy), 32'd0);

    // Single byte 0x55: latency and exact line waveform.
    push(8'h55, 4);
    tx_valid = 1'b0;
    chk("lat_n_count", 32'(fifo_count), 32'd1);
    chk("lat_n_pin", 32'(tx_pin), 32'd1);
    chk("lat_n_busy", 32'(tx_busy), 32'd1);
    step();
    chk("lat_n1_pin", 32'(tx_pin), 32'd1);
    chk("lat_n1_count", 32'(fifo_count), 32'd0);
    f = frame_bits(8'h55);
    for (int i = 0; i < NB * DIV; i++) begin
      step();
      chk("wave55", 32'(tx_pin), 32'(f[i / DIV]));
      if (i == NB * DIV - 2) chk("busy_in_stop", 32'(tx_busy), 32'd1);
      if (i == NB * DIV - 1) chk("busy_after_stop", 32'(tx_busy), 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      chk("idle_high", 32'(tx_pin), 32'd1);
    end
    wait_idle(200);

    // Parity pattern bytes sent back-to-back.
    push(8'h07, 4);
    push(8'h03, 4);
    tx_valid = 1'b0;
    wait_idle(400);

    // Fill the FIFO with valid held; sixth byte waits for a slot.
    push(8'hA1, 4);
    push(8'hA2, 4);
    push(8'hA3, 4);
    push(8'hA4, 4);
    push(8'hA5, 4);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(tx_ready), 32'd0);
    push(8'hA6, 200);
    tx_valid = 1'b0;
    chk("refill_count", 32'(fifo_count), 32'd4);
    wait_idle(2000);

    // Push exactly on the STOP->START pop edge: occupancy must hold.
    push(8'hB1, 4);
    push(8'hB2, 4);
    push(8'hB3, 4);
    tx_valid = 1'b0;
    chk("pre_pop_count", 32'(fifo_count), 32'd2);
    repeat (NB * DIV - 2) @(posedge clk);
    #1;
    chk("at_pop_m1_count", 32'(fifo_count), 32'd2);
    push(8'hB4, 1);
    tx_valid = 1'b0;
    chk("push_pop_count", 32'(fifo_count), 32'd2);
    wait_idle(2000);

    // Minimum divider: 0xFF then 0x00 back-to-back, 2 cycles per bit.
    chk("d2_ready", 32'(tx_ready2), 32'd1);
    tx_data2 = 8'hFF; tx_valid2 = 1'b1;
    step();
    tx_data2 = 8'h00;
    step();
    tx_valid2 = 1'b0;
    chk("d2_count", 32'(fifo_count2), 32'd1);
    fa = frame_bits(8'hFF);
    fz = frame_bits(8'h00);
    for (int i = 0; i < 2 * NB * DIV2; i++) begin
      step();
      j = i / DIV2;
      chk("d2_wave", 32'(tx_pin2), 32'((j < NB) ? fa[j] : fz[j - NB]));
      if (i == 2 * NB * DIV2 - 2) chk("d2_busy_stop", 32'(tx_busy2), 32'd1);
    end
    chk("d2_busy_end", 32'(tx_busy2), 32'd0);
    chk("d2_count_end", 32'(fifo_count2), 32'd0);

    // Reset during DATA bit 3 of 0xF0 with two more bytes queued.
    push(8'hF0, 4);
    push(8'hC1, 4);
    push(8'hC2, 4);
    tx_valid = 1'b0;
    chk("f0_start", 32'(tx_pin), 32'd0);
    repeat (16) step();
    chk("f0_bit3", 32'(tx_pin), 32'd0);
    chk("f0_q_count", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mon_in = 1'b0;
    expect_b2b = 1'b0;
    sbq.delete();
    chk("abort_pin", 32'(tx_pin), 32'd1);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_ready", 32'(tx_ready), 32'd1);
    repeat (60) step();
    chk("quiet_pin", 32'(tx_pin), 32'd1);
    chk("quiet_busy", 32'(tx_busy), 32'd0);
    chk("quiet_count", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
